// File: rtl/id_operand_queue.sv
// id_operand_queue: decode-to-execute issue buffer.
// Holds up to DEPTH decoded bundles with their source operands. Waiting
// entries snoop the write-back port so an instruction never issues stale data.
// The head operands are additionally bypassed combinationally from wb_*.
module id_operand_queue #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 64,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [IDX_W-1:0]           in_rs1_idx,
  input  logic [IDX_W-1:0]           in_rs2_idx,
  input  logic [DATA_W-1:0]          in_rs1_data,
  input  logic [DATA_W-1:0]          in_rs2_data,
  input  logic                       wb_en,
  input  logic [IDX_W-1:0]           wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_rs1_data,
  output logic [DATA_W-1:0]          out_rs2_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]  valid_q;
  logic [CTRL_W-1:0] ctrl_q     [DEPTH];
  logic [IDX_W-1:0]  rs1_idx_q  [DEPTH];
  logic [IDX_W-1:0]  rs2_idx_q  [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_s, deq_s;
  logic [DATA_W-1:0] cap_rs1_s, cap_rs2_s;

  // A write-back matches a source index; x0 never matches.
  function automatic logic wb_hit(input logic en, input logic [IDX_W-1:0] widx,
                                  input logic [IDX_W-1:0] idx);
    return en && (widx == idx) && (idx != {IDX_W{1'b0}});
  endfunction

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != CNT_ZERO);
  assign count     = count_q;

  assign cap_rs1_s = wb_hit(wb_en, wb_idx, in_rs1_idx) ? wb_data : in_rs1_data;
  assign cap_rs2_s = wb_hit(wb_en, wb_idx, in_rs2_idx) ? wb_data : in_rs2_data;

  assign out_ctrl     = ctrl_q[rd_ptr_q];
  assign out_rs1_data = wb_hit(wb_en, wb_idx, rs1_idx_q[rd_ptr_q]) ? wb_data : rs1_data_q[rd_ptr_q];
  assign out_rs2_data = wb_hit(wb_en, wb_idx, rs2_idx_q[rd_ptr_q]) ? wb_data : rs2_data_q[rd_ptr_q];

  // Handshake decode and next pointer/occupancy; flush discards everything.
  always_comb begin
    enq_s    = in_valid && in_ready && !flush;
    deq_s    = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write on enqueue, write-back snoop of waiting entries, invalidate on dequeue.
  // The slot at wr_ptr is never valid when an enqueue fires (queue not full),
  // so a write and a dequeue never target the same slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i]     <= {CTRL_W{1'b0}};
        rs1_idx_q[i]  <= {IDX_W{1'b0}};
        rs2_idx_q[i]  <= {IDX_W{1'b0}};
        rs1_data_q[i] <= {DATA_W{1'b0}};
        rs2_data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      valid_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_s && (wr_ptr_q == PTR_W'(i))) begin
          valid_q[i]    <= 1'b1;
          ctrl_q[i]     <= in_ctrl;
          rs1_idx_q[i]  <= in_rs1_idx;
          rs2_idx_q[i]  <= in_rs2_idx;
          rs1_data_q[i] <= cap_rs1_s;
          rs2_data_q[i] <= cap_rs2_s;
        end else if (valid_q[i]) begin
          if (wb_hit(wb_en, wb_idx, rs1_idx_q[i])) begin
            rs1_data_q[i] <= wb_data;
          end
          if (wb_hit(wb_en, wb_idx, rs2_idx_q[i])) begin
            rs2_data_q[i] <= wb_data;
          end
          if (deq_s && (rd_ptr_q == PTR_W'(i))) begin
            valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/id_operand_queue.md
# id_operand_queue

Parametrised decode-to-execute issue buffer, the successor to the fixed single-entry ID/EXE pipeline register. It holds up to DEPTH decoded instruction bundles with their source-operand values and presents them to EXE under a valid/ready handshake. While an entry waits, it snoops the write-back port and refreshes its stored operands, so a stalled instruction never issues stale register data. It sits between decoder/regfile read and the EXE stage, and supports flush for branch redirection.

## Interface
- DATA_W, 32, register/operand width
- CTRL_W, 64, width of the opaque decoded control bundle (alu op, imm, dmem type, rd, wb ctrl, illegal flag, ...)
- IDX_W, 5, register index width
- DEPTH, 2, number of entries; power of two, ≥2

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous discard of all entries
- in_valid  in  1  decoder has a bundle
- in_ready  out  1  queue can accept (= count != DEPTH)
- in_ctrl  in  CTRL_W  decoded control bundle
- in_rs1_idx, in_rs2_idx  in  IDX_W  source indices
- in_rs1_data, in_rs2_data  in  DATA_W  regfile read values
- wb_en  in  1  write-back enable
- wb_idx  in  IDX_W  write-back index
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  head entry valid
- out_ready  in  1  EXE accepts head
- out_ctrl  out  CTRL_W  head control bundle
- out_rs1_data, out_rs2_data  out  DATA_W  head operands (bypassed)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer of DEPTH entries {valid, ctrl, rs1_idx, rs2_idx, rs1_data, rs2_data}; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue fires when in_valid & in_ready & ~flush; the entry is written at wr_ptr, then wr_ptr increments.
- Dequeue fires when out_valid & out_ready & ~flush; rd_ptr increments and the entry is invalidated.
- Enqueue and dequeue in the same cycle are both allowed (count unchanged). When full, in_ready=0, even if out_ready=1; there is no full-pass-through.
- Capture bypass: on enqueue, if wb_en & wb_idx==in_rsN_idx & in_rsN_idx!=0, store wb_data, otherwise store in_rsN_data.
- Snoop refresh: each cycle, for every valid entry and each source N, if wb_en & wb_idx==rsN_idx & rsN_idx!=0, then rsN_data <= wb_data.
- Output bypass: out_rsN_data = wb_data if wb_en & wb_idx==head rsN_idx & idx!=0; otherwise the stored head value. This path is combinational from the wb_* inputs.
- out_ctrl and the indices come directly from storage at rd_ptr. out_valid = (count!=0).
- Index 0 never matches, so x0 reads always use the captured regfile value.
- Flush: next cycle count=0, both pointers=0, all valid=0. An enqueue or dequeue in the flush cycle is ignored. out_ready is don't-care during flush.

## Timing
- Reset (resetn=0 at posedge): count=0, wr_ptr=rd_ptr=0, all valid=0, all stored ctrl/data=0. The outputs are therefore out_valid=0, in_ready=1, out_ctrl=0, and out_rsN_data=0 unless the wb bypass hits. Reset has priority over flush.
- Latency: a bundle enqueued at edge k is visible with out_valid=1 after edge k (one cycle); there is no combinational in→out path.
- in_ready depends only on count (registered). It is not a function of out_ready.
- A snoop write at edge k updates stored data at k. The output bypass covers the same-cycle write before edge k.
- Reset or flush asserted mid-operation loses pending entries; no partial state remains.
- Throughput: one bundle per cycle sustained when out_ready=1 and count<DEPTH.

## Test plan
- Reset/fill/drain, DEPTH=2: enqueue ctrl=A,B with out_ready=0. Required: count=2, in_ready=0, the third in_valid is held off. Then out_ready=1: A then B issue on consecutive cycles, count reaches 0, and in_ready=1.
- Stale operand refresh: enqueue rs1_idx=5, rs1_data=0x11 with out_ready=0. Next cycle wb_en=1, wb_idx=5, wb_data=0xAA. Two cycles later, assert out_ready. Required: out_rs1_data=0xAA.
- Same-cycle capture and output bypass: enqueue with rs2_idx=3, in_rs2_data=0x1, while wb_idx=3, wb_data=0x22. Required: the head shows 0x22. Then, with the head's rs1_idx=7, apply wb_idx=7, wb_data=0x33 in the dequeue cycle. Required: out_rs1_data=0x33 in that same cycle.
- x0 immunity: rs1_idx=0, in_rs1_data=0, then wb_en=1, wb_idx=0, wb_data=0xFF. Required: out_rs1_data stays 0.
- Flush with simultaneous traffic: count=1 and flush=1 together with in_valid=1 and out_ready=1. Required: count=0 and out_valid=0 next cycle; the incoming bundle is never issued.
- Pointer wrap, DEPTH=4: run 10 bundles with random out_ready stalls. Required: issue order matches enqueue order, and count never exceeds 4 or underflows.
